// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, opcode encoding and command type for the 4-bit
//            ALU and its command sequencer.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 4;
    localparam int ALU_OP_W   = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_GT  = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        alu_op_e               op;
    } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 4-bit combinational ALU. Results wrap modulo 2^ALU_DATA_W;
//            shifts are logical by b; GT returns 1 when a > b (unsigned).
//            rst forces the result to zero.
// Revision : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic                  rst,
    input  logic [ALU_DATA_W-1:0] a,
    input  logic [ALU_DATA_W-1:0] b,
    input  logic [ALU_OP_W-1:0]   op,
    output logic [ALU_DATA_W-1:0] result,
    output logic                  zero
);

    // Opcode decode; result held at zero while in reset
    always_comb begin
        result = '0;
        if (!rst) begin
            case (alu_op_e'(op))
                OP_ADD:  result = a + b;
                OP_SUB:  result = a - b;
                OP_AND:  result = a & b;
                OP_OR:   result = a | b;
                OP_XOR:  result = a ^ b;
                OP_SHL:  result = a << b;
                OP_SHR:  result = a >> b;
                OP_GT:   result = (a > b) ? ALU_DATA_W'(1) : '0;
                default: result = '0;
            endcase
        end
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Brief    : Synchronous FIFO of ALU commands. Head is read combinationally
//            and forced to zero when empty. Push when full and pop when empty
//            are ignored.
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t push_cmd,
    input  logic     pop,
    output alu_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

    alu_cmd_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_cmd;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Issue stage for the 4-bit ALU. Queues {a,b,op} commands, drives
//            the FIFO head to the ALU, registers result/zero/op into a
//            one-deep output slot and counts delivered zero results
//            (saturating at 255).
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_rst,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [OP_W-1:0]   out_op,
    output logic [7:0]        zero_cnt
);

    alu_cmd_t          w_push_cmd;
    alu_cmd_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_fire;
    logic              w_deliver;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic [OP_W-1:0]   r_out_op;
    logic [7:0]        r_zero_cnt;

    // Full FIFO refuses input even if the slot drains this cycle
    assign in_ready  = ~w_full;
    assign w_push    = in_valid & ~w_full;
    assign w_fire    = ~w_empty & (~r_out_valid | out_ready);
    assign w_deliver = r_out_valid & out_ready;

    // Pack incoming fields into the command type
    always_comb begin
        w_push_cmd    = '0;
        w_push_cmd.a  = in_a;
        w_push_cmd.b  = in_b;
        w_push_cmd.op = alu_op_e'(in_op);
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_cmd (w_push_cmd),
        .pop      (w_fire),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign alu_a   = w_head.a;
    assign alu_b   = w_head.b;
    assign alu_op  = w_head.op;
    assign alu_rst = w_empty;

    // Output slot: capture on fire, otherwise drop valid once delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_op     <= '0;
        end else if (w_fire) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            r_out_op     <= w_head.op;
        end else if (w_deliver) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Count delivered zero results, holding at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
        end else if (w_deliver && r_out_zero && (r_zero_cnt != 8'hFF)) begin
            r_zero_cnt <= r_zero_cnt + 8'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_op     = r_out_op;
    assign zero_cnt   = r_zero_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed self-checking bench for alu_cmd_sequencer with the ALU
//            connected back-to-back. Inputs change and outputs are sampled
//            on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_rst;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_zero;
    logic [2:0] out_op;
    logic [7:0] zero_cnt;

    int total = 0;
    int bad   = 0;

    // Streaming vectors: a, b, op, hand-computed result
    logic [3:0] va [16] = '{4'h3, 4'h9, 4'h2, 4'hF, 4'h1, 4'hF, 4'h3, 4'h8,
                            4'h7, 4'h3, 4'h0, 4'hF, 4'h9, 4'hF, 4'hA, 4'h0};
    logic [3:0] vb [16] = '{4'h4, 4'h9, 4'h5, 4'h6, 4'h2, 4'hF, 4'h2, 4'h3,
                            4'h3, 4'h7, 4'h1, 4'hF, 4'h1, 4'h1, 4'h5, 4'h0};
    logic [2:0] vo [16] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                            3'd7, 3'd7, 3'd1, 3'd0, 3'd5, 3'd6, 3'd4, 3'd3};
    logic [3:0] vr [16] = '{4'h7, 4'h2, 4'hD, 4'h6, 4'h3, 4'h0, 4'hC, 4'h1,
                            4'h1, 4'h0, 4'hF, 4'hE, 4'h2, 4'h7, 4'hF, 4'h0};

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_W (4),
        .OP_W   (3),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_rst    (alu_rst),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_op     (out_op),
        .zero_cnt   (zero_cnt)
    );

    alu u_alu (
        .rst    (alu_rst),
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic check_out(input string tag, input logic [3:0] res, input logic z,
                             input logic [2:0] op);
        check({tag, "_valid"},  out_valid,  1);
        check({tag, "_result"}, out_result, res);
        check({tag, "_zero"},   out_zero,   z);
        check({tag, "_op"},     out_op,     op);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 3'd0);

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_result", out_result, 0);
        check("rst_out_zero",   out_zero,   0);
        check("rst_out_op",     out_op,     0);
        check("rst_zero_cnt",   zero_cnt,   0);
        check("rst_alu_rst",    alu_rst,    1);
        check("rst_alu_a",      alu_a,      0);
        check("rst_alu_op",     alu_op,     0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // ---------------- 1: single ADD 3+4 ----------------
        out_ready = 1'b1;
        drive(1'b1, 4'h3, 4'h4, OP_ADD);
        @(negedge clk);
        check("t1_alu_a",   alu_a,   4'h3);
        check("t1_alu_b",   alu_b,   4'h4);
        check("t1_alu_rst", alu_rst, 0);
        check("t1_early_valid", out_valid, 0);
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        @(negedge clk);
        check_out("t1", 4'h7, 1'b0, 3'd0);
        @(negedge clk);
        check("t1_drain_valid", out_valid,  0);
        check("t1_hold_result", out_result, 4'h7);
        check("t1_empty_rst",   alu_rst,    1);

        // ---------------- 2: SUB 5-5 then ADD 15+1 ----------------
        drive(1'b1, 4'h5, 4'h5, OP_SUB);
        @(negedge clk);
        drive(1'b1, 4'hF, 4'h1, OP_ADD);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check_out("t2_sub", 4'h0, 1'b1, 3'd1);
        @(negedge clk);
        check_out("t2_add", 4'h0, 1'b1, 3'd0);
        check("t2_cnt_mid", zero_cnt, 1);
        @(negedge clk);
        check("t2_drain_valid", out_valid, 0);
        check("t2_zero_cnt",    zero_cnt,  2);

        // ---------------- 3: backpressure, fill to full ----------------
        out_ready = 1'b0;
        drive(1'b1, 4'h9, 4'h3, OP_XOR);      // 4'hA
        @(negedge clk);
        drive(1'b1, 4'h8, 4'h1, OP_OR);       // 4'h9
        @(negedge clk);
        check_out("t3_park", 4'hA, 1'b0, 3'd4);
        drive(1'b1, 4'hC, 4'hA, OP_AND);      // 4'h8
        @(negedge clk);
        drive(1'b1, 4'h2, 4'h3, OP_SUB);      // 4'hF
        @(negedge clk);
        drive(1'b1, 4'h7, 4'h7, OP_ADD);      // 4'hE
        @(negedge clk);
        check("t3_full_ready", in_ready, 0);
        drive(1'b1, 4'h5, 4'h5, OP_XOR);      // 4'h0, waits for space
        @(negedge clk);
        check("t3_still_full", in_ready, 0);
        check_out("t3_stall", 4'hA, 1'b0, 3'd4);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("t3_r1", 4'h9, 1'b0, 3'd3);
        check("t3_space_ready", in_ready, 1);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check_out("t3_r2", 4'h8, 1'b0, 3'd2);
        @(negedge clk);
        check_out("t3_r3", 4'hF, 1'b0, 3'd1);
        @(negedge clk);
        check_out("t3_r4", 4'hE, 1'b0, 3'd0);
        @(negedge clk);
        check_out("t3_r5", 4'h0, 1'b1, 3'd4);
        @(negedge clk);
        check("t3_drain_valid", out_valid, 0);
        check("t3_zero_cnt",    zero_cnt,  3);

        // ---------------- 4: streaming 16 commands ----------------
        for (int k = 0; k < 18; k++) begin
            if (k >= 2) begin
                check_out($sformatf("t4_s%0d", k - 2), vr[k-2], (vr[k-2] == 4'h0), vo[k-2]);
            end
            if (k < 16) drive(1'b1, va[k], vb[k], vo[k]);
            else        drive(1'b0, 4'h0, 4'h0, 3'd0);
            @(negedge clk);
        end
        check("t4_drain_valid", out_valid, 0);
        check("t4_zero_cnt",    zero_cnt,  6);

        // ---------------- 5: reset mid-stream ----------------
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 4'h1, OP_ADD);
        @(negedge clk);
        drive(1'b1, 4'h2, 4'h2, OP_ADD);
        @(negedge clk);
        drive(1'b1, 4'h3, 4'h3, OP_ADD);
        @(negedge clk);
        drive(1'b1, 4'h4, 4'h4, OP_ADD);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        check_out("t5_pre", 4'h2, 1'b0, 3'd0);
        check("t5_pre_alu_rst", alu_rst, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid",   out_valid,  0);
        check("t5_rst_result",  out_result, 0);
        check("t5_rst_op",      out_op,     0);
        check("t5_rst_alu_rst", alu_rst,    1);
        check("t5_rst_alu_a",   alu_a,      0);
        check("t5_rst_cnt",     zero_cnt,   0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t5_rel_ready", in_ready, 1);
        drive(1'b1, 4'hA, 4'h5, OP_OR);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 3'd0);
        @(negedge clk);
        check_out("t5_or", 4'hF, 1'b0, 3'd3);
        @(negedge clk);
        check("t5_no_stale", out_valid, 0);
        check("t5_cnt",      zero_cnt,  0);

        // ---------------- 6: zero_cnt saturation ----------------
        for (int k = 0; k < 264; k++) begin
            if (k == 256) check("t6_cnt_254", zero_cnt, 254);
            if (k == 257) check("t6_cnt_255", zero_cnt, 255);
            if (k < 260) drive(1'b1, 4'h0, 4'(k), OP_AND);
            else         drive(1'b0, 4'h0, 4'h0, 3'd0);
            @(negedge clk);
        end
        check("t6_sat_cnt",     zero_cnt,  255);
        check("t6_drain_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
